// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared constants and types for the seven-segment scan decoder
// Contents: HEX_SEG table (active-high gfedcba, index = nibble), SEL_BLANK, state_t.
package seg7_pkg;

  localparam logic [7:0] SEL_BLANK = 8'hFF;

  // Entry [n] is the lit-segment pattern for hex digit n; entry 15 is leftmost.
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HELD   = 2'd2
  } state_t;

endpackage

// File: rtl/seg7_pattern_decode.sv
// rtl/seg7_pattern_decode.sv - active-low 7-segment pattern to hex nibble
// Ports: seg_n[6:0] in (active-low a..g), valid out (pattern is a hex glyph), nibble[3:0] out.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg_n,
  output logic       valid,
  output logic [3:0] nibble
);

  always_comb begin
    valid  = 1'b0;
    nibble = 4'd0;
    // Table entries are unique, so at most one index matches.
    for (int i = 0; i < 16; i++) begin
      if (~seg_n == HEX_SEG[i]) begin
        valid  = 1'b1;
        nibble = 4'(i);
      end
    end
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// rtl/seg7_scan_decoder.sv - rebuilds the 32-bit value shown on a scanned 8-digit display
// Ports: clk, rst (async active-low), seg[7:0]/sel[7:0] active-low inputs;
//        value[31:0], dp_mask[7:0], frame_count, err_count outputs;
//        frame_valid, value_changed, err_pattern, err_sel one-cycle pulses.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       seg,
  input  logic [7:0]       sel,
  output logic [31:0]      value,
  output logic             frame_valid,
  output logic             value_changed,
  output logic [7:0]       dp_mask,
  output logic             err_pattern,
  output logic             err_sel,
  output logic [CNT_W-1:0] frame_count,
  output logic [CNT_W-1:0] err_count
);

  localparam logic [7:0] STABLE_MAX = 8'(STABLE_CYCLES);

  // Registered input sample and the sample from the cycle before it.
  logic [7:0] s_seg_q, s_seg_d, s_sel_q, s_sel_d;
  logic [7:0] p_seg_q, p_seg_d, p_sel_q, p_sel_d;
  logic [7:0] cnt_q, cnt_d;
  state_t     state_q, state_d;

  // Working frame being assembled, and which digits have been captured.
  logic [31:0] work_value_q, work_value_d;
  logic [7:0]  work_dp_q, work_dp_d;
  logic [7:0]  seen_q, seen_d;

  logic [31:0]      value_q, value_d;
  logic [7:0]       dp_mask_q, dp_mask_d;
  logic             frame_valid_q, frame_valid_d;
  logic             value_changed_q, value_changed_d;
  logic             err_pattern_q, err_pattern_d;
  logic             err_sel_q, err_sel_d;
  logic [CNT_W-1:0] frame_count_q, frame_count_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;

  logic       dec_valid;
  logic [3:0] dec_nibble;
  logic       changed;
  logic [7:0] cnt_cur;
  logic       eval;
  logic [7:0] sel_n;
  logic       multi_sel;
  logic [2:0] dig_idx;

  seg7_pattern_decode u_decode (
    .seg_n  (s_seg_q[6:0]),
    .valid  (dec_valid),
    .nibble (dec_nibble)
  );

  always_comb begin
    s_seg_d         = seg;
    s_sel_d         = sel;
    p_seg_d         = s_seg_q;
    p_sel_d         = s_sel_q;
    state_d         = state_q;
    work_value_d    = work_value_q;
    work_dp_d       = work_dp_q;
    seen_d          = seen_q;
    value_d         = value_q;
    dp_mask_d       = dp_mask_q;
    frame_valid_d   = 1'b0;
    value_changed_d = 1'b0;
    err_pattern_d   = 1'b0;
    err_sel_d       = 1'b0;
    frame_count_d   = frame_count_q;
    err_count_d     = err_count_q;
    eval            = 1'b0;

    changed = (s_seg_q != p_seg_q) || (s_sel_q != p_sel_q);

    // cnt_cur is how many cycles the current sample has been held, this cycle included.
    if (changed) begin
      cnt_cur = 8'd1;
    end else if (cnt_q >= STABLE_MAX) begin
      cnt_cur = STABLE_MAX;
    end else begin
      cnt_cur = cnt_q + 8'd1;
    end
    cnt_d = cnt_cur;

    case (state_q)
      IDLE: begin
        if (s_sel_q != SEL_BLANK) begin
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (s_sel_q == SEL_BLANK) begin
          state_d = IDLE;
        end else if (cnt_cur == STABLE_MAX) begin
          eval    = 1'b1;
          state_d = HELD;
        end
      end
      HELD: begin
        if (changed) begin
          state_d = (s_sel_q == SEL_BLANK) ? IDLE : SETTLE;
        end
      end
      default: state_d = IDLE;
    endcase

    sel_n     = ~s_sel_q;
    multi_sel = (sel_n & (sel_n - 8'd1)) != 8'd0;
    dig_idx   = 3'd0;
    for (int k = 0; k < 8; k++) begin
      if (sel_n[k]) begin
        dig_idx = 3'(k);
      end
    end

    // SETTLE never evaluates a blank sample, so not multi_sel means exactly one digit.
    if (eval) begin
      if (multi_sel) begin
        err_sel_d = 1'b1;
      end else if (!dec_valid) begin
        err_pattern_d = 1'b1;
      end else begin
        work_value_d[{dig_idx, 2'b00} +: 4] = dec_nibble;
        work_dp_d[dig_idx]                  = ~s_seg_q[7];
        seen_d[dig_idx]                     = 1'b1;
        if (seen_d == 8'hFF) begin
          value_d         = work_value_d;
          dp_mask_d       = work_dp_d;
          frame_valid_d   = 1'b1;
          value_changed_d = (work_value_d != value_q);
          frame_count_d   = frame_count_q + CNT_W'(1);
          seen_d          = 8'h00;
        end
      end
    end

    if ((err_pattern_d || err_sel_d) && (err_count_q != {CNT_W{1'b1}})) begin
      err_count_d = err_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_seg_q         <= 8'h00;
      s_sel_q         <= 8'h00;
      p_seg_q         <= 8'h00;
      p_sel_q         <= 8'h00;
      cnt_q           <= 8'h00;
      state_q         <= IDLE;
      work_value_q    <= 32'h0;
      work_dp_q       <= 8'h00;
      seen_q          <= 8'h00;
      value_q         <= 32'h0;
      dp_mask_q       <= 8'h00;
      frame_valid_q   <= 1'b0;
      value_changed_q <= 1'b0;
      err_pattern_q   <= 1'b0;
      err_sel_q       <= 1'b0;
      frame_count_q   <= '0;
      err_count_q     <= '0;
    end else begin
      s_seg_q         <= s_seg_d;
      s_sel_q         <= s_sel_d;
      p_seg_q         <= p_seg_d;
      p_sel_q         <= p_sel_d;
      cnt_q           <= cnt_d;
      state_q         <= state_d;
      work_value_q    <= work_value_d;
      work_dp_q       <= work_dp_d;
      seen_q          <= seen_d;
      value_q         <= value_d;
      dp_mask_q       <= dp_mask_d;
      frame_valid_q   <= frame_valid_d;
      value_changed_q <= value_changed_d;
      err_pattern_q   <= err_pattern_d;
      err_sel_q       <= err_sel_d;
      frame_count_q   <= frame_count_d;
      err_count_q     <= err_count_d;
    end
  end

  assign value         = value_q;
  assign dp_mask       = dp_mask_q;
  assign frame_valid   = frame_valid_q;
  assign value_changed = value_changed_q;
  assign err_pattern   = err_pattern_q;
  assign err_sel       = err_sel_q;
  assign frame_count   = frame_count_q;
  assign err_count     = err_count_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb/tb_seg7_scan_decoder.sv - scoreboard bench for seg7_scan_decoder
module tb_seg7_scan_decoder;

  localparam int STABLE = 4;
  localparam int CNT_W  = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [7:0]       seg = 8'hFF;
  logic [7:0]       sel = 8'hFF;
  logic [31:0]      value;
  logic             frame_valid, value_changed, err_pattern, err_sel;
  logic [7:0]       dp_mask;
  logic [CNT_W-1:0] frame_count, err_count;

  always #5 clk = ~clk;

  seg7_scan_decoder #(.STABLE_CYCLES(STABLE), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .seg           (seg),
    .sel           (sel),
    .value         (value),
    .frame_valid   (frame_valid),
    .value_changed (value_changed),
    .dp_mask       (dp_mask),
    .err_pattern   (err_pattern),
    .err_sel       (err_sel),
    .frame_count   (frame_count),
    .err_count     (err_count)
  );

  // kind: 0 = frame, 1 = pattern error, 2 = select error
  typedef struct {
    int          kind;
    logic [31:0] value;
    logic [7:0]  dp;
    logic        changed;
    logic [15:0] fcount;
    logic [15:0] ecount;
  } ev_t;

  ev_t exp_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Reference model: the display is a sequence of held samples; a sample
  // held at least STABLE cycles with a digit selected is evaluated once.
  logic [7:0]  m_sel, m_seg;
  int          m_len;
  bit          m_done;
  logic [31:0] m_work, m_last;
  logic [7:0]  m_dp, m_seen;
  logic [15:0] m_fc, m_ec;

  function automatic int glyph_index(input logic [6:0] lit);
    for (int i = 0; i < 16; i++) if (hex_tab[i] == lit) return i;
    return -1;
  endfunction

  function automatic logic [7:0] seg_of(input logic [3:0] n, input logic dp);
    logic [6:0] t;
    t = hex_tab[n];
    return {~dp, ~t};
  endfunction

  task automatic model_reset();
    m_sel = 8'hFF; m_seg = 8'hFF; m_len = 0; m_done = 1'b1;
    m_work = 0; m_last = 0; m_dp = 0; m_seen = 0; m_fc = 0; m_ec = 0;
  endtask

  task automatic model_eval();
    logic [7:0] low;
    logic [6:0] lit;
    int nlow, k, d;
    ev_t e;
    low = ~m_sel; nlow = 0; k = 0;
    for (int i = 0; i < 8; i++) if (low[i]) begin nlow++; k = i; end
    e = '{kind: 0, value: 0, dp: 0, changed: 0, fcount: 0, ecount: 0};
    lit = ~m_seg[6:0];
    d = glyph_index(lit);
    if (nlow > 1 || d < 0) begin
      if (m_ec != 16'hFFFF) m_ec = m_ec + 16'd1;
      e.kind = (nlow > 1) ? 2 : 1;
      e.ecount = m_ec;
      exp_q.push_back(e);
    end else begin
      m_work[k*4 +: 4] = 4'(d);
      m_dp[k] = ~m_seg[7];
      m_seen[k] = 1'b1;
      if (m_seen == 8'hFF) begin
        m_fc = m_fc + 16'd1;
        e.kind = 0; e.value = m_work; e.dp = m_dp;
        e.changed = (m_work != m_last); e.fcount = m_fc;
        m_last = m_work;
        m_seen = 0;
        exp_q.push_back(e);
      end
    end
  endtask

  // Model first (so expectations are queued before the DUT can react), then drive.
  task automatic run(input logic [7:0] s, input logic [7:0] g, input int n);
    if (s != m_sel || g != m_seg) begin
      m_sel = s; m_seg = g; m_len = 0; m_done = 1'b0;
    end
    m_len += n;
    if (!m_done && m_len >= STABLE && s != 8'hFF) begin
      model_eval();
      m_done = 1'b1;
    end
    sel = s; seg = g;
    repeat (n) @(negedge clk);
  endtask

  task automatic digit(input int d, input logic [31:0] v, input logic [7:0] dp, input int dwell);
    logic [7:0] one;
    one = 8'h01 << d;
    run(~one, seg_of(v[d*4 +: 4], dp[d]), dwell);
  endtask

  task automatic scan(input logic [31:0] v, input logic [7:0] dp, input int dwell);
    for (int d = 0; d < 8; d++) digit(d, v, dp, dwell);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic drain();
    int t;
    run(8'hFF, 8'hFF, 4);
    t = 0;
    while (exp_q.size() != 0 && t < 20) begin
      @(negedge clk);
      t++;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expected events never seen, want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    #2;
    check("rst_value", value, 32'h0);
    check("rst_dp_mask", {24'h0, dp_mask}, 32'h0);
    check("rst_pulses", {28'h0, frame_valid, value_changed, err_pattern, err_sel}, 32'h0);
    check("rst_frame_count", {16'h0, frame_count}, 32'h0);
    check("rst_err_count", {16'h0, err_count}, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    model_reset();
    run(8'hFF, 8'hFF, 3);
  endtask

  // Monitor: every DUT pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    ev_t e;
    bit ok;
    if (rst) begin
      if (frame_valid || err_pattern || err_sel) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_event: got fv=%b ep=%b es=%b value=%h, want no event",
                   frame_valid, err_pattern, err_sel, value);
        end else begin
          e = exp_q.pop_front();
          case (e.kind)
            0: ok = frame_valid && !err_pattern && !err_sel && value == e.value &&
                    dp_mask == e.dp && value_changed == e.changed && frame_count == e.fcount;
            1: ok = err_pattern && !frame_valid && !err_sel && !value_changed && err_count == e.ecount;
            default: ok = err_sel && !frame_valid && !err_pattern && !value_changed && err_count == e.ecount;
          endcase
          if (!ok) begin
            n_bad++;
            $display("FAIL event_k%0d: got fv=%b ep=%b es=%b vc=%b value=%h dp=%h fc=%0d ec=%0d, want value=%h dp=%h vc=%b fc=%0d ec=%0d",
                     e.kind, frame_valid, err_pattern, err_sel, value_changed, value, dp_mask,
                     frame_count, err_count, e.value, e.dp, e.changed, e.fcount, e.ecount);
          end
        end
      end else if (value_changed) begin
        n_cmp++;
        n_bad++;
        $display("FAIL lone_value_changed: got vc=1 want 0 without frame_valid");
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rv;
    logic [7:0]  rdp;
    int          order [8];
    model_reset();
    repeat (3) @(negedge clk);
    do_reset();

    // Basic frame, then the same frame twice more (no change reported).
    scan(32'h12345678, 8'h00, 6);
    drain();
    check("t1_frame_count", {16'h0, frame_count}, 32'd1);
    check("t1_value", value, 32'h12345678);
    scan(32'h12345678, 8'h00, 6);
    scan(32'h12345678, 8'h00, 6);
    drain();
    check("t2_frame_count", {16'h0, frame_count}, 32'd3);

    // Short dwell on digit 3 must not capture it.
    for (int d = 0; d < 8; d++) digit(d, 32'hA5C396F0, 8'h81, (d == 3) ? 3 : 6);
    drain();
    check("t3_no_frame", {16'h0, frame_count}, 32'd3);
    digit(3, 32'hA5C396F0, 8'h81, 4);
    drain();
    check("t3_value", value, 32'hA5C396F0);
    check("t3_dp", {24'h0, dp_mask}, 32'h81);

    // Blank pattern on digit 2, then a good digit 2.
    digit(0, 32'h0BADF00D, 8'h00, 6);
    digit(1, 32'h0BADF00D, 8'h00, 6);
    run(8'hFB, 8'hFF, 6);
    for (int d = 2; d < 8; d++) digit(d, 32'h0BADF00D, 8'h00, 6);
    drain();
    check("t4_err_count", {16'h0, err_count}, 32'd1);

    // Two digits selected at once.
    for (int d = 0; d < 4; d++) digit(d, 32'h76543210, 8'h10, 5);
    run(8'hFC, 8'h80, 5);
    for (int d = 4; d < 8; d++) digit(d, 32'h76543210, 8'h10, 5);
    drain();
    check("t5_err_count", {16'h0, err_count}, 32'd2);

    // Reset mid-frame discards the partial digits.
    for (int d = 0; d < 5; d++) digit(d, 32'h55555555, 8'h00, 6);
    drain();
    do_reset();
    scan(32'hDEADBEEF, 8'h00, 6);
    drain();
    check("t6_value", value, 32'hDEADBEEF);
    check("t6_frame_count", {16'h0, frame_count}, 32'd1);

    // Randomised scans: shuffled digit order, varied dwell, injected errors and blanks.
    for (int it = 0; it < 40; it++) begin
      rv  = $urandom;
      rdp = 8'($urandom);
      for (int i = 0; i < 8; i++) order[i] = i;
      for (int i = 7; i > 0; i--) begin
        int j, t;
        j = $urandom_range(i, 0);
        t = order[i]; order[i] = order[j]; order[j] = t;
      end
      for (int i = 0; i < 8; i++) begin
        int r;
        r = $urandom_range(99, 0);
        if (r < 8) begin
          run(~(8'h01 << order[i]), 8'($urandom), $urandom_range(6, 4));
        end else if (r < 14) begin
          int a, b;
          a = $urandom_range(7, 0);
          b = (a + $urandom_range(7, 1)) % 8;
          run(8'hFF ^ ((8'h01 << a) | (8'h01 << b)), seg_of(4'($urandom), 1'b0), $urandom_range(6, 4));
        end else if (r < 22) begin
          run(8'hFF, 8'($urandom), $urandom_range(2, 1));
        end
        digit(order[i], rv, rdp, $urandom_range(8, 2));
      end
    end
    drain();
    check("final_value", value, m_last);
    check("final_frame_count", {16'h0, frame_count}, {16'h0, m_fc});
    check("final_err_count", {16'h0, err_count}, {16'h0, m_ec});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
